// File: rtl/dmux_1xn_stream.sv
// ---------------------------------------------------------------------------
// dmux_1xn_stream
//
// Registered 1-to-N stream demultiplexer. A single producer presents a word
// together with a destination index. The word is steered into the holding
// register of that channel, and each consumer drains its own channel through
// a valid/ready handshake.
//
// Each channel has one WIDTH-bit data register and one valid bit. A channel
// that is being drained can be refilled in the same cycle, so a single
// channel can sustain one word per clock.
//
// Words addressed to a non-existent channel (in_sel >= N) are always accepted
// and then discarded. Each one produces a one-cycle err_sel pulse.
//
// Optional feature (macro DMUX_BCAST_EN):
//   Adds the in_bcast input. A broadcast word ignores in_sel. It waits until
//   every channel can take it, and then loads all channels at once.
//
// Parameters:
//   WIDTH  data width in bits
//   N      number of output channels (N >= 2)
//   SEL_W  select width, 2**SEL_W >= N
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    input payload
//   in_sel     destination channel index
//   in_valid   producer offers in_data/in_sel
//   in_bcast   (DMUX_BCAST_EN only) load every channel with in_data
//   in_ready   word accepted this cycle (combinational from out_ready)
//   out_data   channel k payload in bits [k*WIDTH +: WIDTH]
//   out_valid  channel k holds a valid word
//   out_ready  consumer k takes its word this cycle
//   err_sel    registered one-cycle pulse per dropped out-of-range word
// ---------------------------------------------------------------------------
module dmux_1xn_stream #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
`ifdef DMUX_BCAST_EN
  input  logic               in_bcast,
`endif
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               err_sel
);

  logic [WIDTH-1:0] data_q [N];
  logic [N-1:0]     valid_q;

  logic [N-1:0]     sel_hit;
  logic [N-1:0]     chan_free;
  logic [N-1:0]     load;
  logic             sel_in_range;
  logic             is_bcast;
  logic             accept;
  logic             drop;

`ifdef DMUX_BCAST_EN
  assign is_bcast = in_bcast;
`else
  assign is_bcast = 1'b0;
`endif

  // One-hot decode of in_sel over the channels that actually exist.
  // An all-zero result means the index is out of range. This avoids any
  // out-of-bounds indexing into the per-channel vectors.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
      end
    end
  end

  assign sel_in_range = |sel_hit;

  // A channel can take a new word if it is empty or is draining this cycle.
  assign chan_free = ~valid_q | out_ready;

  // Only the addressed channel gates acceptance. Out-of-range words are
  // never stalled because they go nowhere. A broadcast word needs all
  // channels free at the same time.
  always_comb begin
    in_ready = 1'b1;
    if (is_bcast) begin
      in_ready = &chan_free;
    end else if (sel_in_range) begin
      in_ready = |(sel_hit & chan_free);
    end
  end

  assign accept = in_valid & in_ready;
  assign load   = accept ? (is_bcast ? {N{1'b1}} : sel_hit) : {N{1'b0}};
  assign drop   = accept & ~is_bcast & ~sel_in_range;

  // Per-channel holding registers.
  // A refill takes priority over a drain, so a channel that is drained and
  // refilled in the same cycle stays valid and produces no bubble.
  // Data is written only on a load. This keeps a stalled word bit-stable and
  // leaves the last word visible on an idle channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_sel <= 1'b0;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      err_sel <= drop;
    end
  end

  assign out_valid = valid_q;

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_data[k*WIDTH +: WIDTH] = data_q[k];
  end

endmodule

// File: tb/tb_dmux_1xn_stream.sv
// ---------------------------------------------------------------------------
// tb_dmux_1xn_stream
//
// Self-checking bench for dmux_1xn_stream. It drives two instances from the
// same producer inputs:
//   - a 4-channel instance (2-bit select, every index valid)
//   - a 3-channel instance (2-bit select, index 3 is out of range)
// The expected in_ready, out_valid, out_data and err_sel values come from a
// small per-channel queue model that lives inside the bench.
// When DMUX_BCAST_EN is defined, the bench also drives broadcast traffic.
// ---------------------------------------------------------------------------
module tb_dmux_1xn_stream;

  logic        clk;
  logic        rst;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
`ifdef DMUX_BCAST_EN
  logic        in_bcast;
`endif

  logic        in_ready4;
  logic [15:0] out_data4;
  logic [3:0]  out_valid4;
  logic [3:0]  out_ready4;
  logic        err_sel4;

  logic        in_ready3;
  logic [11:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        err_sel3;

  // Reference model state: occupancy and last payload per channel, plus the
  // expected err_sel value for each instance.
  logic [3:0]  mv4, mv3;
  logic [15:0] md4, md3;
  logic        me4, me3;

  int checks;
  int errors;

  dmux_1xn_stream #(.WIDTH(4), .N(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
`ifdef DMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .err_sel   (err_sel4)
  );

  dmux_1xn_stream #(.WIDTH(4), .N(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
`ifdef DMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .err_sel   (err_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something goes badly wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected readiness from the channel occupancy of an n-channel demux.
  function automatic logic expReady(input int n, input logic [3:0] v,
                                    input logic [3:0] r, input int sel,
                                    input logic bc);
    logic ok;
    ok = 1'b1;
    if (bc) begin
      for (int c = 0; c < n; c++) begin
        if (v[c] && !r[c]) ok = 1'b0;
      end
    end else if (sel < n) begin
      ok = !v[sel] || r[sel];
    end
    return ok;
  endfunction

  // Advance one model by one clock: accepted words land in their channel.
  // Channels that are drained and not refilled empty out.
  task automatic modelStep(input int n, input logic acc, input int sel,
                           input logic [3:0] din, input logic [3:0] r,
                           input logic bc, inout logic [3:0] v,
                           inout logic [15:0] d, output logic e);
    e = acc && !bc && (sel >= n);
    for (int c = 0; c < n; c++) begin
      if (acc && (bc || sel == c)) begin
        v[c] = 1'b1;
        d[c*4 +: 4] = din;
      end else if (v[c] && r[c]) begin
        v[c] = 1'b0;
      end
    end
  endtask

  task automatic checkAllOutputs();
    checkOutput("out_valid4", {28'd0, out_valid4}, {28'd0, mv4});
    checkOutput("out_data4",  {16'd0, out_data4},  {16'd0, md4});
    checkOutput("err_sel4",   {31'd0, err_sel4},   {31'd0, me4});
    checkOutput("out_valid3", {29'd0, out_valid3}, {29'd0, mv3[2:0]});
    checkOutput("out_data3",  {20'd0, out_data3},  {20'd0, md3[11:0]});
    checkOutput("err_sel3",   {31'd0, err_sel3},   {31'd0, me3});
  endtask

  // Drive one cycle of producer and consumer inputs.
  // Called shortly after a rising edge: in_ready is checked mid-cycle and
  // the registered outputs are checked just after the next edge.
  task automatic applyStimulus(input logic [3:0] din, input logic [1:0] sel,
                               input logic vld, input logic [3:0] rdy,
                               input logic bc);
    logic er4, er3;
    in_data    = din;
    in_sel     = sel;
    in_valid   = vld;
    out_ready4 = rdy;
    out_ready3 = rdy[2:0];
`ifdef DMUX_BCAST_EN
    in_bcast   = bc;
`endif
    er4 = expReady(4, mv4, rdy, int'(sel), bc);
    er3 = expReady(3, mv3, {1'b0, rdy[2:0]}, int'(sel), bc);
    #3;
    checkOutput("in_ready4", {31'd0, in_ready4}, {31'd0, er4});
    checkOutput("in_ready3", {31'd0, in_ready3}, {31'd0, er3});
    @(posedge clk);
    #1;
    modelStep(4, vld && er4, int'(sel), din, rdy, bc, mv4, md4, me4);
    modelStep(3, vld && er3, int'(sel), din, {1'b0, rdy[2:0]}, bc, mv3, md3, me3);
    checkAllOutputs();
  endtask

  // Hold reset for two cycles while the producer offers a word. Nothing may
  // be captured, and any word already held is discarded.
  task automatic doReset();
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 2'd1;
    in_data    = 4'hA;
    out_ready4 = 4'b0000;
    out_ready3 = 3'b000;
`ifdef DMUX_BCAST_EN
    in_bcast   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    mv4 = '0; md4 = '0; me4 = 1'b0;
    mv3 = '0; md3 = '0; me3 = 1'b0;
    checkAllOutputs();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    doReset();

    // Basic steering with all consumers ready.
    applyStimulus(4'h3, 2'd0, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'h5, 2'd1, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'h9, 2'd2, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'hF, 2'd3, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111, 1'b0);

    // Channel 2 stalls. Its second word is back-pressured, but channel 0
    // still flows. Releasing channel 2 drains and refills it in one cycle.
    applyStimulus(4'h6, 2'd2, 1'b1, 4'b1011, 1'b0);
    applyStimulus(4'h7, 2'd2, 1'b1, 4'b1011, 1'b0);
    applyStimulus(4'hC, 2'd0, 1'b1, 4'b1011, 1'b0);
    applyStimulus(4'h7, 2'd2, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111, 1'b0);

    // Full-rate streaming into a single channel.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'(i), 2'd1, 1'b1, 4'b1111, 1'b0);
    end
    applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111, 1'b0);

    // Index 3 is out of range for the 3-channel instance: it is dropped and
    // pulses err_sel once. The 4-channel instance takes it into channel 3.
    applyStimulus(4'hE, 2'd3, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111, 1'b0);

`ifdef DMUX_BCAST_EN
    // A stalled channel 3 blocks the broadcast on the 4-channel instance.
    // Once channel 3 is released, all channels load the broadcast word.
    applyStimulus(4'h2, 2'd3, 1'b1, 4'b0111, 1'b0);
    applyStimulus(4'hB, 2'd0, 1'b1, 4'b0111, 1'b1);
    applyStimulus(4'hB, 2'd0, 1'b1, 4'b1111, 1'b1);
    applyStimulus(4'h0, 2'd0, 1'b0, 4'b1111, 1'b0);
`endif

    // Randomized traffic with independent consumer stalls.
    for (int i = 0; i < 400; i++) begin
      logic bc;
      bc = 1'b0;
`ifdef DMUX_BCAST_EN
      bc = ($urandom_range(0, 7) == 0);
`endif
      applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), bc);
    end

    // A reset in the middle of traffic discards any held words.
    doReset();
    applyStimulus(4'h4, 2'd2, 1'b1, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
